// File: rtl/dot_product_pkg.sv
// Shared types and parameter derivations for the dot-product update sequencer.
package dot_product_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ISSUE = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    function automatic int calc_num_groups(input int vector_size, input int rows_per_clk);
        return vector_size / rows_per_clk;
    endfunction

    function automatic int calc_addr_width(input int num_groups);
        return (num_groups > 1) ? $clog2(num_groups) : 1;
    endfunction

    function automatic int calc_cnt_width(input int num_groups);
        return $clog2(num_groups + 1);
    endfunction

endpackage

// File: rtl/dot_product_sequencer_if.sv
// Bundle of the control, datapath and J-memory signals around the sequencer.
interface dot_product_sequencer_if
    import dot_product_pkg::*;
#(
    parameter int NUM_ROWS_PER_CLK = 4,
    parameter int VECTOR_SIZE      = 256
);
    localparam int ADDR_WIDTH = calc_addr_width(calc_num_groups(VECTOR_SIZE, NUM_ROWS_PER_CLK));

    logic                        start;
    logic [VECTOR_SIZE-1:0]      sigma;
    logic [VECTOR_SIZE-1:0]      flip_mask;
    logic                        busy;
    logic                        done;
    logic                        err;
    logic                        dp_clear;
    logic [NUM_ROWS_PER_CLK-1:0] j_rows_valid;
    logic [NUM_ROWS_PER_CLK-1:0] sigma_bits;
    logic                        dp_done;
    logic                        mem_req;
    logic                        mem_ready;
    logic [ADDR_WIDTH-1:0]       mem_addr;

    modport master (
        output start, sigma, flip_mask, dp_done, mem_ready,
        input  busy, done, err, dp_clear, j_rows_valid, sigma_bits, mem_req, mem_addr
    );

    modport slave (
        input  start, sigma, flip_mask, dp_done, mem_ready,
        output busy, done, err, dp_clear, j_rows_valid, sigma_bits, mem_req, mem_addr
    );

endinterface

// File: rtl/dot_product_sequencer_valid_align_pipe.sv
// Fixed-depth shift pipe that delays {row mask, sigma} to meet the J read data.
module valid_align_pipe #(
    parameter int DATA_W = 4,
    parameter int STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_mask,
    input  logic [DATA_W-1:0] i_sigma,
    output logic [DATA_W-1:0] o_mask,
    output logic [DATA_W-1:0] o_sigma,
    output logic              o_empty
);

    logic [STAGES-1:0] r_vld_p;
    logic [DATA_W-1:0] r_mask_p  [STAGES];
    logic [DATA_W-1:0] r_sigma_p [STAGES];

    // Stage 0 loads on push, later stages shift; idle slots carry zeros so outputs stay quiet.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p <= '0;
            for (int i = 0; i < STAGES; i++) begin
                r_mask_p[i]  <= '0;
                r_sigma_p[i] <= '0;
            end
        end else begin
            r_vld_p[0]   <= i_push;
            r_mask_p[0]  <= i_push ? i_mask  : '0;
            r_sigma_p[0] <= i_push ? i_sigma : '0;
            for (int i = 1; i < STAGES; i++) begin
                r_vld_p[i]   <= r_vld_p[i-1];
                r_mask_p[i]  <= r_mask_p[i-1];
                r_sigma_p[i] <= r_sigma_p[i-1];
            end
        end
    end

    assign o_mask  = r_mask_p[STAGES-1];
    assign o_sigma = r_sigma_p[STAGES-1];
    assign o_empty = ~|r_vld_p;

endmodule

// File: rtl/dot_product_sequencer.sv
// Walks the J matrix in row groups, feeds aligned valid/sigma to the datapath and
// signals completion once every issued group has been accumulated.
module dot_product_sequencer
    import dot_product_pkg::*;
#(
    parameter int NUM_ROWS_PER_CLK = 4,
    parameter int VECTOR_SIZE      = 256,
    parameter int READ_LATENCY     = 2,
    parameter int SKIP_EMPTY       = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    dot_product_sequencer_if.slave bus
);

    localparam int NUM_GROUPS = calc_num_groups(VECTOR_SIZE, NUM_ROWS_PER_CLK);
    localparam int ADDR_WIDTH = calc_addr_width(NUM_GROUPS);
    localparam int CNT_WIDTH  = calc_cnt_width(NUM_GROUPS);
    localparam logic [ADDR_WIDTH-1:0] LAST_G = ADDR_WIDTH'(NUM_GROUPS - 1);

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [VECTOR_SIZE-1:0]      r_sigma;
    logic [VECTOR_SIZE-1:0]      r_mask;
    logic [ADDR_WIDTH-1:0]       r_g;
    logic [CNT_WIDTH-1:0]        r_outst;
    logic                        r_busy;
    logic                        r_done;
    logic                        r_err;
    logic                        r_dp_clear;

    logic [NUM_ROWS_PER_CLK-1:0] w_mask_slice;
    logic [NUM_ROWS_PER_CLK-1:0] w_sigma_slice;
    logic [NUM_ROWS_PER_CLK-1:0] w_pipe_mask;
    logic [NUM_ROWS_PER_CLK-1:0] w_pipe_sigma;
    logic                        w_pipe_empty;
    logic                        w_skip;
    logic                        w_req;
    logic                        w_accept;
    logic                        w_advance;
    logic                        w_last;
    logic                        w_inc;
    logic                        w_dec;
    logic                        w_start_acc;

    always_comb begin
        w_mask_slice  = r_mask[int'(r_g) * NUM_ROWS_PER_CLK +: NUM_ROWS_PER_CLK];
        w_sigma_slice = r_sigma[int'(r_g) * NUM_ROWS_PER_CLK +: NUM_ROWS_PER_CLK];
    end

    assign w_start_acc = (r_state == IDLE) && bus.start;
    assign w_skip      = (SKIP_EMPTY != 0) && (w_mask_slice == '0);
    assign w_req       = (r_state == ISSUE) && !w_skip;
    assign w_accept    = w_req && bus.mem_ready;
    assign w_advance   = (r_state == ISSUE) && (w_skip || bus.mem_ready);
    assign w_last      = (r_g == LAST_G);
    // A zero-mask group requested with skipping disabled never produces a dp_done.
    assign w_inc       = w_accept && (w_mask_slice != '0);
    assign w_dec       = bus.dp_done;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_nxt = CLEAR;
            CLEAR:   w_state_nxt = ISSUE;
            ISSUE:   if (w_advance && w_last) w_state_nxt = DRAIN;
            DRAIN:   if (w_pipe_empty && (r_outst == '0)) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_g        <= '0;
            r_outst    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_dp_clear <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_busy     <= (w_state_nxt != IDLE);
            r_done     <= (w_state_nxt == DONE);
            r_dp_clear <= (w_state_nxt == CLEAR);

            if (r_state == CLEAR) begin
                r_g <= '0;
            end else if (w_advance && !w_last) begin
                r_g <= r_g + ADDR_WIDTH'(1);
            end

            if (w_inc && !w_dec) begin
                r_outst <= r_outst + CNT_WIDTH'(1);
            end else if (!w_inc && w_dec && (r_outst != '0)) begin
                r_outst <= r_outst - CNT_WIDTH'(1);
            end

            if (w_start_acc) begin
                r_err <= 1'b0;
            end else if (w_dec && !w_inc && (r_outst == '0)) begin
                r_err <= 1'b1;
            end
        end
    end

    // Pass operands are data only: captured on an accepted start, never reset.
    always_ff @(posedge clk) begin
        if (w_start_acc) begin
            r_sigma <= bus.sigma;
            r_mask  <= bus.flip_mask;
        end
    end

    valid_align_pipe #(
        .DATA_W (NUM_ROWS_PER_CLK),
        .STAGES (READ_LATENCY)
    ) u_align (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_accept),
        .i_mask  (w_mask_slice),
        .i_sigma (w_sigma_slice),
        .o_mask  (w_pipe_mask),
        .o_sigma (w_pipe_sigma),
        .o_empty (w_pipe_empty)
    );

    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.err          = r_err;
    assign bus.dp_clear     = r_dp_clear;
    assign bus.j_rows_valid = w_pipe_mask;
    assign bus.sigma_bits   = w_pipe_sigma;
    assign bus.mem_req      = w_req;
    assign bus.mem_addr     = r_g;

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Randomized bench: per-pass expectation tables built from the group-walk rules.
module tb_dot_product_sequencer;

    localparam int N     = 4;
    localparam int VS    = 256;
    localparam int NG    = 64;
    localparam int L     = 2;
    localparam int DPLAT = 3;
    localparam int MAXC  = 600;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    dot_product_sequencer_if #(.NUM_ROWS_PER_CLK(N), .VECTOR_SIZE(VS)) bus();

    dot_product_sequencer #(
        .NUM_ROWS_PER_CLK (N),
        .VECTOR_SIZE      (VS),
        .READ_LATENCY     (L),
        .SKIP_EMPTY       (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic       exp_busy  [MAXC];
    logic       exp_done  [MAXC];
    logic       exp_err   [MAXC];
    logic       exp_clear [MAXC];
    logic       exp_req   [MAXC];
    logic [5:0] exp_addr  [MAXC];
    logic [3:0] exp_jv    [MAXC];
    logic [3:0] exp_sig   [MAXC];
    logic       drv_ready [MAXC];
    logic       drv_dpdone[MAXC];
    logic [3:0] obs_jv    [MAXC];
    logic [3:0] obs_sig   [MAXC];

    int   cur_k = 0;
    logic chk_en = 1'b0;
    int   obs_req_cnt, obs_acc, obs_first_req, obs_first_addr;
    int   obs_done_cnt, obs_done_cyc, obs_clear_cnt, obs_clear_cyc;
    logic obs_err_last;

    task automatic check(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", nm, k, got, exp);
        end
    endtask

    function automatic logic [VS-1:0] rnd256();
        logic [VS-1:0] r;
        for (int i = 0; i < VS/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic clear_tables();
        for (int k = 0; k < MAXC; k++) begin
            exp_busy[k] = 0; exp_done[k] = 0; exp_err[k] = 0; exp_clear[k] = 0;
            exp_req[k] = 0; exp_addr[k] = '0; exp_jv[k] = '0; exp_sig[k] = '0;
            drv_dpdone[k] = 0;
        end
    endtask

    // Expected behaviour of one pass: walk the groups, skip empty ones in one cycle,
    // wait on ready for the rest; data returns L cycles after acceptance and the
    // datapath answers DPLAT cycles after that.
    task automatic build_pass(input logic [VS-1:0] msk, input logic [VS-1:0] sg,
                              input logic err_in, output int plen);
        int c, last_acc, last_dp, dcyc;
        logic [3:0] m;
        clear_tables();
        exp_err[0]   = err_in;
        exp_clear[1] = 1;
        c = 2; last_acc = -100; last_dp = -100;
        for (int g = 0; g < NG; g++) begin
            m = msk[g*N +: N];
            if (m == 0) begin
                c++;
            end else begin
                while (!drv_ready[c] && c < MAXC - 16) begin
                    exp_req[c] = 1; exp_addr[c] = 6'(g); c++;
                end
                exp_req[c] = 1; exp_addr[c] = 6'(g);
                exp_jv[c+L]  = m;
                exp_sig[c+L] = sg[g*N +: N];
                drv_dpdone[c+L+DPLAT] = 1;
                last_acc = c; last_dp = c + L + DPLAT;
                c++;
            end
        end
        dcyc = c;
        if (last_dp + 1 > dcyc) dcyc = last_dp + 1;
        if (last_acc + L + 1 > dcyc) dcyc = last_acc + L + 1;
        dcyc++;
        exp_done[dcyc] = 1;
        for (int k = 1; k <= dcyc; k++) exp_busy[k] = 1;
        plen = dcyc + 3;
    endtask

    task automatic set_ready_all();
        for (int k = 0; k < MAXC; k++) drv_ready[k] = 1;
    endtask

    task automatic set_ready_toggle();
        for (int k = 0; k < MAXC; k++) drv_ready[k] = (k < 2) || ((k - 2) % 3 == 0);
    endtask

    task automatic set_ready_random();
        int zeros = 0;
        for (int k = 0; k < MAXC; k++) begin
            drv_ready[k] = ($urandom_range(0, 9) < 6) || (zeros >= 3);
            zeros = drv_ready[k] ? 0 : zeros + 1;
        end
    endtask

    task automatic run_pass(input int plen, input logic do_start, input int rst_at,
                            input logic [VS-1:0] msk, input logic [VS-1:0] sg);
        obs_req_cnt = 0; obs_acc = 0; obs_first_req = -1; obs_first_addr = -1;
        obs_done_cnt = 0; obs_done_cyc = -1; obs_clear_cnt = 0; obs_clear_cyc = -1;
        for (int k = 0; k < plen; k++) begin
            @(posedge clk); #1;
            cur_k         = k;
            chk_en        = 1'b1;
            bus.start     = do_start && (k == 0);
            bus.sigma     = (k == 0) ? sg  : rnd256();
            bus.flip_mask = (k == 0) ? msk : rnd256();
            bus.mem_ready = drv_ready[k];
            bus.dp_done   = drv_dpdone[k];
            rst           = (k == rst_at);
        end
        @(posedge clk); #1;
        chk_en = 1'b0;
        bus.start = 0; bus.dp_done = 0; bus.mem_ready = 0; rst = 0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",         cur_k, 32'(bus.busy),         32'(exp_busy[cur_k]));
            check("done",         cur_k, 32'(bus.done),         32'(exp_done[cur_k]));
            check("err",          cur_k, 32'(bus.err),          32'(exp_err[cur_k]));
            check("dp_clear",     cur_k, 32'(bus.dp_clear),     32'(exp_clear[cur_k]));
            check("mem_req",      cur_k, 32'(bus.mem_req),      32'(exp_req[cur_k]));
            check("j_rows_valid", cur_k, 32'(bus.j_rows_valid), 32'(exp_jv[cur_k]));
            check("sigma_bits",   cur_k, 32'(bus.sigma_bits),   32'(exp_sig[cur_k]));
            if (exp_req[cur_k])
                check("mem_addr", cur_k, 32'(bus.mem_addr), 32'(exp_addr[cur_k]));
            if (bus.mem_req) begin
                obs_req_cnt++;
                if (obs_first_req < 0) begin
                    obs_first_req  = cur_k;
                    obs_first_addr = int'(bus.mem_addr);
                end
                if (bus.mem_ready) obs_acc++;
            end
            if (bus.done) begin obs_done_cnt++; obs_done_cyc = cur_k; end
            if (bus.dp_clear) begin obs_clear_cnt++; obs_clear_cyc = cur_k; end
            obs_jv[cur_k]  = bus.j_rows_valid;
            obs_sig[cur_k] = bus.sigma_bits;
            obs_err_last   = bus.err;
        end
    end

    initial begin
        logic [VS-1:0] msk, sg;
        int plen;

        rst = 1; bus.start = 0; bus.sigma = '0; bus.flip_mask = '0;
        bus.dp_done = 0; bus.mem_ready = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy",     -1, 32'(bus.busy),         32'd0);
        check("rst_done",     -1, 32'(bus.done),         32'd0);
        check("rst_err",      -1, 32'(bus.err),          32'd0);
        check("rst_dp_clear", -1, 32'(bus.dp_clear),     32'd0);
        check("rst_mem_req",  -1, 32'(bus.mem_req),      32'd0);
        check("rst_mem_addr", -1, 32'(bus.mem_addr),     32'd0);
        check("rst_jv",       -1, 32'(bus.j_rows_valid), 32'd0);
        check("rst_sig",      -1, 32'(bus.sigma_bits),   32'd0);
        @(posedge clk); #1; rst = 0;
        repeat (2) @(posedge clk);

        // Full mask, memory always ready.
        msk = '1; sg = rnd256();
        set_ready_all(); build_pass(msk, sg, 1'b0, plen);
        run_pass(plen, 1'b1, -1, msk, sg);
        check("full_accepts",   -1, 32'(obs_acc),        32'd64);
        check("full_first_req", -1, 32'(obs_first_req),  32'd2);
        check("full_first_adr", -1, 32'(obs_first_addr), 32'd0);
        check("full_clear_cnt", -1, 32'(obs_clear_cnt),  32'd1);
        check("full_clear_cyc", -1, 32'(obs_clear_cyc),  32'd1);
        check("full_done_cnt",  -1, 32'(obs_done_cnt),   32'd1);
        check("full_done_cyc",  -1, 32'(obs_done_cyc),   32'd72);

        // Only row 9 selected.
        msk = '0; msk[9] = 1'b1; sg = rnd256();
        build_pass(msk, sg, 1'b0, plen);
        run_pass(plen, 1'b1, -1, msk, sg);
        check("row9_req_cnt", -1, 32'(obs_req_cnt),    32'd1);
        check("row9_addr",    -1, 32'(obs_first_addr), 32'd2);
        check("row9_req_cyc", -1, 32'(obs_first_req),  32'd4);
        check("row9_jv",      -1, 32'(obs_jv[6]),      32'b0010);
        check("row9_sig",     -1, 32'(obs_sig[6][1]),  32'(sg[9]));

        // Empty mask: every group skipped.
        msk = '0; sg = rnd256();
        build_pass(msk, sg, 1'b0, plen);
        run_pass(plen, 1'b1, -1, msk, sg);
        check("zero_req_cnt",  -1, 32'(obs_req_cnt),  32'd0);
        check("zero_done_cyc", -1, 32'(obs_done_cyc), 32'd67);
        check("zero_done_cnt", -1, 32'(obs_done_cnt), 32'd1);

        // Ready pattern 1,0,0 repeating.
        msk = '1; sg = rnd256();
        set_ready_toggle(); build_pass(msk, sg, 1'b0, plen);
        run_pass(plen, 1'b1, -1, msk, sg);
        check("tog_accepts",  -1, 32'(obs_acc),      32'd64);
        check("tog_done_cnt", -1, 32'(obs_done_cnt), 32'd1);

        // Spurious dp_done while idle sets err, which persists until the next start.
        clear_tables();
        drv_dpdone[2] = 1;
        for (int k = 3; k < 12; k++) exp_err[k] = 1;
        run_pass(12, 1'b0, -1, '0, '0);
        check("spur_err_held", -1, 32'(obs_err_last), 32'd1);
        msk = rnd256(); sg = rnd256();
        set_ready_random(); build_pass(msk, sg, 1'b1, plen);
        run_pass(plen, 1'b1, -1, msk, sg);
        check("after_err_done_cnt", -1, 32'(obs_done_cnt), 32'd1);

        // Reset at cycle 20 aborts the pass silently.
        msk = '1; sg = rnd256();
        set_ready_all(); build_pass(msk, sg, 1'b0, plen);
        for (int k = 21; k < MAXC; k++) begin
            exp_busy[k] = 0; exp_done[k] = 0; exp_err[k] = 0; exp_clear[k] = 0;
            exp_req[k] = 0; exp_jv[k] = '0; exp_sig[k] = '0; drv_dpdone[k] = 0;
        end
        run_pass(26, 1'b1, 20, msk, sg);
        check("abort_done_cnt", -1, 32'(obs_done_cnt), 32'd0);
        msk = '1; sg = rnd256();
        build_pass(msk, sg, 1'b0, plen);
        run_pass(plen, 1'b1, -1, msk, sg);
        check("fresh_done_cyc", -1, 32'(obs_done_cyc), 32'd72);

        // Random sparse masks with random memory stalls.
        for (int p = 0; p < 4; p++) begin
            msk = '0;
            for (int g = 0; g < NG; g++)
                if ($urandom_range(0, 1) == 1) msk[g*N +: N] = 4'($urandom);
            sg = rnd256();
            set_ready_random(); build_pass(msk, sg, 1'b0, plen);
            run_pass(plen, 1'b1, -1, msk, sg);
            check("rand_done_cnt", p, 32'(obs_done_cnt), 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
